// File: rtl/puf_rng_packer.sv
// rtl/puf_rng_packer.sv - packs raw PUF samples into whitened RNG words with a repetition-count health test
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   enable, mode  packing runs only when enable=1 and mode=0 (rng)
//   bit_done      level from the PUF; a rising edge marks a new sample
//   bit_data      raw IN_W-bit sample
//   whiten        OUT_W-bit XOR key applied to each completed word
//   es_rng_req    gates presentation of the held word
//   rng_ack       consumer accepts the presented word
//   alert_clr     clears the sticky health alert
//   rng_data      presented word (zero when not valid)
//   rng_valid     word available
//   rct_alert     sticky repetition-count failure
//   drop_cnt      saturating count of words lost to a full output register
//
// Legal parameters: OUT_W a multiple of IN_W, OUT_W >= 2*IN_W, RCT_CUT >= 2.

module puf_rng_packer #(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 4,
  parameter int RCT_CUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic             bit_done,
  input  logic [IN_W-1:0]  bit_data,
  input  logic [OUT_W-1:0] whiten,
  input  logic             es_rng_req,
  input  logic             rng_ack,
  input  logic             alert_clr,
  output logic [OUT_W-1:0] rng_data,
  output logic             rng_valid,
  output logic             rct_alert,
  output logic [7:0]       drop_cnt
);

  localparam int K      = OUT_W / IN_W;
  localparam int FCNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int REP_W  = $clog2(RCT_CUT + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(K - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(RCT_CUT);

  logic              bit_done_dly_q, bit_done_dly_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              out_full_q, out_full_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [IN_W-1:0]   last_q, last_d;
  logic              alert_q, alert_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              strobe;
  logic              final_strobe;
  logic              ack_acc;
  logic [OUT_W-1:0]  shifted;
  logic [OUT_W-1:0]  word;

  assign rng_valid = out_full_q & es_rng_req;
  assign rng_data  = rng_valid ? out_q : '0;
  assign rct_alert = alert_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    bit_done_dly_d = bit_done;
    fcnt_d         = fcnt_q;
    acc_d          = acc_q;
    out_d          = out_q;
    out_full_d     = out_full_q;
    rep_cnt_d      = rep_cnt_q;
    last_d         = last_q;
    alert_d        = alert_q;
    drop_cnt_d     = drop_cnt_q;

    strobe       = bit_done & ~bit_done_dly_q & enable & ~mode;
    final_strobe = strobe && (fcnt_q == FCNT_LAST);
    ack_acc      = rng_ack & rng_valid;
    shifted      = {acc_q[OUT_W-IN_W-1:0], bit_data};
    word         = shifted ^ whiten;

    // Fill state is only meaningful while actively packing.
    if (!enable || mode) begin
      fcnt_d = '0;
      acc_d  = '0;
    end else if (strobe) begin
      if (final_strobe) begin
        fcnt_d = '0;
        acc_d  = '0;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
        acc_d  = shifted;
      end
    end

    if (ack_acc) begin
      out_full_d = 1'b0;
    end

    // A word completed during an alert is silently discarded; otherwise it
    // either lands in the output register (empty, or freed by a same-cycle
    // ack) or is counted as dropped.
    if (final_strobe && !alert_q) begin
      if (!out_full_q || ack_acc) begin
        out_d      = word;
        out_full_d = 1'b1;
      end else if (drop_cnt_q != 8'hff) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end

    // After reset or alert_clr rep_cnt is 0, so the next strobe yields 1
    // whether or not it matches the remembered sample.
    if (strobe) begin
      last_d = bit_data;
      if (bit_data == last_q) begin
        rep_cnt_d = (rep_cnt_q == REP_MAX) ? REP_MAX : rep_cnt_q + 1'b1;
      end else begin
        rep_cnt_d = REP_W'(1);
      end
    end

    // Clear beats a same-cycle set.
    if (alert_clr) begin
      rep_cnt_d = '0;
      alert_d   = 1'b0;
    end else if (rep_cnt_d == REP_MAX) begin
      alert_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_done_dly_q <= 1'b0;
      fcnt_q         <= '0;
      acc_q          <= '0;
      out_q          <= '0;
      out_full_q     <= 1'b0;
      rep_cnt_q      <= '0;
      last_q         <= '0;
      alert_q        <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      bit_done_dly_q <= bit_done_dly_d;
      fcnt_q         <= fcnt_d;
      acc_q          <= acc_d;
      out_q          <= out_d;
      out_full_q     <= out_full_d;
      rep_cnt_q      <= rep_cnt_d;
      last_q         <= last_d;
      alert_q        <= alert_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_puf_rng_packer.sv
// tb/tb_puf_rng_packer.sv - self-checking bench for puf_rng_packer (IN_W=2, OUT_W=4, RCT_CUT=8)

module tb_puf_rng_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       mode;
  logic       bit_done;
  logic [1:0] bit_data;
  logic [3:0] whiten;
  logic       es_rng_req;
  logic       rng_ack;
  logic       alert_clr;
  logic [3:0] rng_data;
  logic       rng_valid;
  logic       rct_alert;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [1:0] s0;
    logic [1:0] s1;
    logic [3:0] w;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  puf_rng_packer #(.IN_W(2), .OUT_W(4), .RCT_CUT(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .bit_done(bit_done), .bit_data(bit_data), .whiten(whiten),
    .es_rng_req(es_rng_req), .rng_ack(rng_ack), .alert_clr(alert_clr),
    .rng_data(rng_data), .rng_valid(rng_valid), .rct_alert(rct_alert),
    .drop_cnt(drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One sample: bit_done high for a cycle (rising edge), then low for a cycle.
  // rng_ack / alert_clr set by the caller apply only to the strobe cycle.
  task automatic smp(input logic [1:0] d);
    bit_data = d;
    bit_done = 1'b1;
    tick();
    bit_done  = 1'b0;
    rng_ack   = 1'b0;
    alert_clr = 1'b0;
    tick();
  endtask

  task automatic ack();
    rng_ack = 1'b1;
    tick();
    rng_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_word(input string nm);
    logic [3:0] e;
    int n;
    e = exp_q.pop_front();
    n = 0;
    while (!rng_valid && n < 4) begin
      tick();
      n++;
    end
    chk({nm, " valid"}, 32'(rng_valid), 32'd1);
    chk({nm, " data"}, 32'(rng_data), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b1; mode = 1'b0; bit_done = 1'b0; bit_data = 2'b00;
    whiten = 4'b0000; es_rng_req = 1'b1; rng_ack = 1'b0; alert_clr = 1'b0;

    tbl[0] = '{s0: 2'b10, s1: 2'b01, w: 4'b0011, exp: 4'b1010};
    tbl[1] = '{s0: 2'b11, s1: 2'b00, w: 4'b0000, exp: 4'b1100};
    tbl[2] = '{s0: 2'b00, s1: 2'b11, w: 4'b1111, exp: 4'b1100};
    tbl[3] = '{s0: 2'b01, s1: 2'b10, w: 4'b0101, exp: 4'b0011};
    tbl[4] = '{s0: 2'b11, s1: 2'b11, w: 4'b1010, exp: 4'b0101};
    tbl[5] = '{s0: 2'b10, s1: 2'b00, w: 4'b1000, exp: 4'b0000};

    do_reset();
    chk("reset valid", 32'(rng_valid), 32'd0);
    chk("reset data", 32'(rng_data), 32'd0);
    chk("reset drop", 32'(drop_cnt), 32'd0);
    chk("reset alert", 32'(rct_alert), 32'd0);

    // Table-driven basic packing, each word acknowledged.
    for (int i = 0; i < 6; i++) begin
      whiten = tbl[i].w;
      smp(tbl[i].s0);
      smp(tbl[i].s1);
      exp_q.push_back(tbl[i].exp);
      expect_word($sformatf("vec%0d", i));
      ack();
      chk($sformatf("vec%0d ack", i), 32'(rng_valid), 32'd0);
    end
    whiten = 4'b0000;

    // Gating by es_rng_req; ack while not valid is ignored.
    es_rng_req = 1'b0;
    smp(2'b01);
    smp(2'b10);
    exp_q.push_back(4'b0110);
    chk("gate valid", 32'(rng_valid), 32'd0);
    chk("gate data", 32'(rng_data), 32'd0);
    ack();
    es_rng_req = 1'b1;
    expect_word("gate word");
    ack();
    chk("gate ack", 32'(rng_valid), 32'd0);

    // Overflow: three words unacked, first held, two dropped.
    smp(2'b10); smp(2'b11);
    smp(2'b00); smp(2'b01);
    smp(2'b11); smp(2'b10);
    exp_q.push_back(4'b1011);
    expect_word("ovf held");
    chk("ovf drop", 32'(drop_cnt), 32'd2);

    // Word completes in the same cycle the held word is acked.
    smp(2'b01);
    rng_ack = 1'b1;
    smp(2'b00);
    exp_q.push_back(4'b0100);
    expect_word("same-cycle");
    chk("same-cycle drop", 32'(drop_cnt), 32'd2);
    ack();
    chk("same-cycle ack", 32'(rng_valid), 32'd0);

    // Saturation: 300 unacked words.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [1:0] a;
      a = i[1:0];
      smp(a);
      smp(~a);
    end
    exp_q.push_back(4'b0011);
    expect_word("sat held");
    chk("sat drop", 32'(drop_cnt), 32'd255);
    ack();

    // Health: 8 identical samples trip the alert.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      smp(2'b11);
      if (i == 3) chk("rct before cut", 32'(rct_alert), 32'd0);
      smp(2'b11);
      exp_q.push_back(4'b1111);
      expect_word($sformatf("rct word%0d", i));
      ack();
    end
    chk("rct alert", 32'(rct_alert), 32'd1);
    smp(2'b01);
    smp(2'b10);
    chk("rct hidden valid", 32'(rng_valid), 32'd0);
    chk("rct hidden drop", 32'(drop_cnt), 32'd0);
    alert_clr = 1'b1;
    tick();
    alert_clr = 1'b0;
    chk("rct cleared", 32'(rct_alert), 32'd0);
    smp(2'b10);
    smp(2'b01);
    exp_q.push_back(4'b1001);
    expect_word("rct resume");
    ack();

    // Clear wins over a same-cycle alert set.
    do_reset();
    for (int i = 0; i < 7; i++) smp(2'b00);
    chk("clr pre alert", 32'(rct_alert), 32'd0);
    alert_clr = 1'b1;
    smp(2'b00);
    chk("clr wins", 32'(rct_alert), 32'd0);

    // Mode change mid-fill discards the partial word.
    do_reset();
    smp(2'b10);
    mode = 1'b1;
    tick(); tick(); tick();
    mode = 1'b0;
    smp(2'b01);
    smp(2'b11);
    exp_q.push_back(4'b0111);
    expect_word("mode midfill");
    ack();

    // Reset mid-fill.
    do_reset();
    smp(2'b10);
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst midfill valid", 32'(rng_valid), 32'd0);
    chk("rst midfill drop", 32'(drop_cnt), 32'd0);
    smp(2'b01);
    smp(2'b11);
    exp_q.push_back(4'b0111);
    expect_word("rst midfill");
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
